rs_enc_framer: RTL and testbench

// Upstream stage of the RS encoder. Accepts an unframed symbol stream with valid/ready and a packet-last marker.

---
 rtl/rs_enc_framer_pkg.sv | 15 +
 rtl/rs_enc_framer_if.sv | 28 ++
 rtl/rs_enc_framer_fifo.sv | 51 +++++
 rtl/rs_enc_framer.sv | 142 ++++++++++++++
 tb/tb_rs_enc_framer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_enc_framer_pkg.sv
// Shared definitions for the RS encoder input framer: default code geometry
// and the framer state encoding.
package rs_codec_pkg;

  localparam int unsigned DEF_WORD_LENGTH = 8;
  localparam int unsigned DEF_N           = 15;
  localparam int unsigned DEF_K           = 11;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    PAD
  } framer_state_e;

endpackage

// File: rtl/rs_enc_framer_if.sv
// Symbol stream in (valid/ready/last) and encoder-facing symbol stream out.
interface rs_enc_framer_if
  import rs_codec_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = DEF_WORD_LENGTH
);

  logic                   s_valid;
  logic [WORD_LENGTH-1:0] s_symbol;
  logic                   s_last;
  logic                   s_ready;
  logic                   m_in_ready;
  logic                   m_valid;
  logic                   m_start_codeword;
  logic                   m_end_codeword;
  logic [WORD_LENGTH-1:0] m_symbol;

  modport master (
    output s_valid, s_symbol, s_last, m_in_ready,
    input  s_ready, m_valid, m_start_codeword, m_end_codeword, m_symbol
  );

  modport slave (
    input  s_valid, s_symbol, s_last, m_in_ready,
    output s_ready, m_valid, m_start_codeword, m_end_codeword, m_symbol
  );

endinterface

// File: rtl/rs_enc_framer_fifo.sv
// Synchronous FIFO for {last, symbol} entries; push ignored when full, pop
// ignored when empty.
module rs_sym_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB separates the full case from the empty case.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/rs_enc_framer.sv
// Cuts a buffered symbol stream into K-symbol messages for the RS encoder,
// padding or shortening the final codeword of each packet.
module rs_enc_framer
  import rs_codec_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int unsigned N           = DEF_N,
  parameter int unsigned K           = DEF_K,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PAD_SHORT   = 0
) (
  input  logic                clk,
  input  logic                rst,
  rs_enc_framer_if.slave      bus,
  output logic                o_busy,
  output logic [15:0]         o_codeword_cnt
);

  localparam int unsigned CW    = $clog2(K + 1);
  localparam logic [CW-1:0] K_C   = CW'(K);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  framer_state_e          state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   valid_q, valid_d, start_q, start_d, end_q, end_d;
  logic [WORD_LENGTH-1:0] sym_q, sym_d;
  logic [15:0]            cwcnt_q, cwcnt_d;

  logic                   fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [WORD_LENGTH:0]   fifo_head;
  logic                   head_last, out_fire, load_end, pad_end;

  assign bus.s_ready = !rst && !fifo_full;
  assign fifo_push   = bus.s_valid && bus.s_ready;

  rs_sym_fifo #(
    .WIDTH (WORD_LENGTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   ({bus.s_last, bus.s_symbol}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_last = fifo_head[WORD_LENGTH];
  assign out_fire  = valid_q && bus.m_in_ready;
  assign cnt_inc   = cnt_q + ONE_C;
  assign load_end  = (cnt_inc == K_C) || ((PAD_SHORT == 0) && head_last);
  // A pad following a lone first symbol always closes the codeword.
  assign pad_end   = (cnt_q == ONE_C) || (cnt_inc == K_C);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    start_d  = start_q;
    end_d    = end_q;
    sym_d    = sym_q;
    cwcnt_d  = cwcnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          valid_d  = 1'b1;
          start_d  = 1'b1;
          end_d    = 1'b0;
          sym_d    = fifo_head[WORD_LENGTH-1:0];
          cnt_d    = ONE_C;
          state_d  = head_last ? PAD : SEND;
        end
      end
      SEND: begin
        if (out_fire && end_q) begin
          valid_d = 1'b0;
          start_d = 1'b0;
          end_d   = 1'b0;
          sym_d   = '0;
          cwcnt_d = cwcnt_q + 16'd1;
          state_d = IDLE;
        end else if (!valid_q || out_fire) begin
          start_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            valid_d  = 1'b1;
            sym_d    = fifo_head[WORD_LENGTH-1:0];
            cnt_d    = cnt_inc;
            end_d    = load_end;
            if (head_last && !load_end) state_d = PAD;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      PAD: begin
        if (out_fire) begin
          valid_d = 1'b1;
          start_d = 1'b0;
          sym_d   = '0;
          cnt_d   = cnt_inc;
          end_d   = pad_end;
          if (pad_end) state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      sym_q   <= '0;
      cwcnt_q <= '0;
    end else begin
      assert (N > K && K >= 2);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      start_q <= start_d;
      end_q   <= end_d;
      sym_q   <= sym_d;
      cwcnt_q <= cwcnt_d;
    end
  end

  assign bus.m_valid          = valid_q;
  assign bus.m_start_codeword = start_q;
  assign bus.m_end_codeword   = end_q;
  assign bus.m_symbol         = sym_q;
  assign o_busy               = (state_q != IDLE) || !fifo_empty;
  assign o_codeword_cnt       = cwcnt_q;

endmodule

// File: tb/tb_rs_enc_framer.sv
// Runs a shortening (PAD_SHORT=0) and a padding (PAD_SHORT=1) framer on the
// same packets and compares every encoder-side transfer with a packet model.
module tb_rs_enc_framer;
  import rs_codec_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned KK = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic         sv[2], sl[2], rdy[2];
  logic [W-1:0] ssym[2];
  logic         mv[2], ms[2], me[2], srdy[2], busy[2];
  logic [W-1:0] msym[2];
  logic [15:0]  cnt[2];

  rs_enc_framer_if #(.WORD_LENGTH(W)) ifc[2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign ifc[g].s_valid    = sv[g];
    assign ifc[g].s_symbol   = ssym[g];
    assign ifc[g].s_last     = sl[g];
    assign ifc[g].m_in_ready = rdy[g];
    assign mv[g]   = ifc[g].m_valid;
    assign ms[g]   = ifc[g].m_start_codeword;
    assign me[g]   = ifc[g].m_end_codeword;
    assign msym[g] = ifc[g].m_symbol;
    assign srdy[g] = ifc[g].s_ready;
    rs_enc_framer #(
      .WORD_LENGTH (W),
      .N           (15),
      .K           (KK),
      .FIFO_DEPTH  (4),
      .PAD_SHORT   (g)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (ifc[g]),
      .o_busy         (busy[g]),
      .o_codeword_cnt (cnt[g])
    );
  end

  logic [W:0]   src_q[2][$];
  logic [10:0]  exp_q[2][$];
  logic [10:0]  prev[2];
  int unsigned  exp_cnt[2], xfer_n[2], stop_at[2], par[2], last_cyc[2];
  bit           stall[2], held[2];
  bit           rnd, b2b;
  int unsigned  cyc, n_chk, n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected encoder transfers for one packet: K-symbol chunks, a lone
  // symbol gets one zero pad as end, PAD_SHORT=1 fills a short tail to K.
  task automatic add_pkt(input logic [W-1:0] p[$]);
    int unsigned n, pos, len, total;
    bit fin;
    n = p.size();
    for (int unsigned j = 0; j < n; j++) begin
      src_q[0].push_back({j == n - 1, p[j]});
      src_q[1].push_back({j == n - 1, p[j]});
    end
    for (int i = 0; i < 2; i++) begin
      pos = 0;
      while (pos < n) begin
        len = (n - pos > KK) ? KK : n - pos;
        fin = (pos + len == n);
        if (len == 1) begin
          exp_q[i].push_back({1'b0, 1'b1, 1'b0, p[pos]});
          exp_q[i].push_back({1'b0, 1'b0, 1'b1, 8'h00});
        end else begin
          total = (fin && i == 1 && len < KK) ? KK : len;
          for (int unsigned j = 0; j < total; j++)
            exp_q[i].push_back({1'b0, j == 0, j == total - 1, (j < len) ? p[pos + j] : 8'h00});
        end
        exp_cnt[i]++;
        pos += len;
      end
    end
  endtask

  task automatic step();
    bit sfire[2];
    logic [10:0] cur, want;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      sfire[i] = sv[i] && srdy[i] && !rst;
      cur = {mv[i], ms[i], me[i], msym[i]};
      if (held[i] && !rst) chk("hold", cur, prev[i]);
      held[i] = mv[i] && !rdy[i] && !rst;
      prev[i] = cur;
      if (mv[i] && rdy[i] && !rst) begin
        want = (exp_q[i].size() != 0) ? exp_q[i].pop_front() : 11'h7FF;
        chk("xfer", {1'b0, ms[i], me[i], msym[i]}, want);
        if (b2b && !ms[i]) chk("b2b_gap", cyc - last_cyc[i], 1);
        last_cyc[i] = cyc;
        xfer_n[i]++;
        if (me[i]) par[i] = 4;
        if (xfer_n[i] >= stop_at[i]) stall[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (sfire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      if (rst) sv[i] = 1'b0;
      else if (!sv[i] || sfire[i]) begin
        if (src_q[i].size() != 0 && (!rnd || $urandom_range(3) != 0)) begin
          sv[i] = 1'b1;
          {sl[i], ssym[i]} = src_q[i][0];
        end else sv[i] = 1'b0;
      end
      if (par[i] > 0) begin
        rdy[i] = 1'b0;
        par[i]--;
      end else if (stall[i]) rdy[i] = 1'b0;
      else rdy[i] = rnd ? ($urandom_range(3) != 0) : 1'b1;
    end
  endtask

  function automatic bit all_idle();
    return exp_q[0].size() == 0 && exp_q[1].size() == 0 && src_q[0].size() == 0 &&
           src_q[1].size() == 0 && !sv[0] && !sv[1];
  endfunction

  task automatic drain();
    int unsigned n = 0;
    while (!all_idle() && n < 3000) begin
      step();
      n++;
    end
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk("drain_exp", exp_q[i].size(), 0);
      chk("cw_cnt", cnt[i], exp_cnt[i] & 32'hFFFF);
      chk("idle_busy", busy[i], 0);
      chk("idle_valid", mv[i], 0);
    end
  endtask

  initial begin
    logic [W-1:0] p[$];
    int unsigned n;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sl[i] = 1'b0; ssym[i] = '0; rdy[i] = 1'b1;
      exp_cnt[i] = 0; xfer_n[i] = 0; stop_at[i] = 32'hFFFF_FFFF; par[i] = 0;
      stall[i] = 1'b0; held[i] = 1'b0; last_cyc[i] = 0;
    end
    rnd = 1'b0; b2b = 1'b0; cyc = 0; n_chk = 0; n_bad = 0;

    repeat (3) step();
    for (int i = 0; i < 2; i++)
      chk("rst_outs", {mv[i], ms[i], me[i], msym[i], srdy[i], busy[i], cnt[i]}, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("rel_sready", srdy[i], 1);
      chk("rel_mvalid", mv[i], 0);
    end

    p = {};
    for (int j = 1; j <= 11; j++) p.push_back(8'(j));
    b2b = 1'b1;
    add_pkt(p);
    drain();
    b2b = 1'b0;

    stall[0] = 1'b1; stall[1] = 1'b1;
    p = {};
    for (int j = 0; j < 11; j++) p.push_back(8'($urandom_range(255)));
    add_pkt(p);
    repeat (12) step();
    for (int i = 0; i < 2; i++) begin
      chk("bp_sready", srdy[i], 0);
      chk("bp_start", {mv[i], ms[i], me[i], msym[i]}, {1'b1, 1'b1, 1'b0, p[0]});
    end
    stall[0] = 1'b0; stall[1] = 1'b0;
    drain();

    rnd = 1'b1;
    p = {};
    for (int j = 0; j < 5; j++) p.push_back(8'($urandom_range(1, 255)));
    add_pkt(p);
    drain();
    p = {8'hAA};
    add_pkt(p);
    drain();
    p = {};
    for (int j = 0; j < 24; j++) p.push_back(8'($urandom_range(255)));
    add_pkt(p);
    drain();
    for (int k = 0; k < 8; k++) begin
      p = {};
      n = $urandom_range(1, 26);
      for (int unsigned j = 0; j < n; j++) p.push_back(8'($urandom_range(255)));
      add_pkt(p);
      drain();
    end

    p = {};
    for (int j = 0; j < 20; j++) p.push_back(8'($urandom_range(255)));
    add_pkt(p);
    for (int i = 0; i < 2; i++) stop_at[i] = xfer_n[i] + 5;
    n = 0;
    while (!(stall[0] && stall[1]) && n < 2000) begin
      step();
      n++;
    end
    chk("stop_reached", {stall[0], stall[1]}, 2'b11);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      exp_cnt[i] = 0;
    end
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stall[i] = 1'b0; stop_at[i] = 32'hFFFF_FFFF; par[i] = 0;
    end
    step();
    for (int i = 0; i < 2; i++)
      chk("mid_rst", {cnt[i], mv[i], busy[i], srdy[i]}, {16'h0, 1'b0, 1'b0, 1'b1});
    repeat (20) step();
    p = {8'h11, 8'h22, 8'h33};
    add_pkt(p);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
